// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one SRAM controller port between the instruction-fetch (IF) and
//   load/store (MEM) requesters. MEM has fixed priority. After STARVE_LIMIT
//   consecutive MEM completions while IF was waiting, IF is forced to win.
//   Once an op stalls on the bus, the grant is locked to its owner until it
//   completes.
//
// Handshake: a requester raises *_read_op / *_write_op and holds op, addr and
//   data stable while its *_stall is 1. An op completes in the cycle it owns
//   the bus with bus_stall=0; that edge is the hand-off and the only cycle in
//   which *_data_read carries valid data. Dropping an op while stalled aborts
//   it and releases the lock.
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   if_addr, if_read_op            IF request (IF never writes)
//   if_data_read, if_stall         IF response
//   mem_addr, mem_read_op,
//   mem_write_op, mem_data_write   MEM request (read+write together = write)
//   mem_data_read, mem_stall       MEM response
//   bus_addr, bus_read_op,
//   bus_write_op, bus_data_write   to SRAM controller
//   bus_data_read, bus_stall       from SRAM controller
//   grant                          {mem,if} one-hot owner this cycle, 00 = none
module sram_bus_arbiter #(
   parameter int ADDR_WIDTH   = 20,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_read_op,
   output logic [DATA_WIDTH-1:0] if_data_read,
   output logic                  if_stall,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_read_op,
   input  logic                  mem_write_op,
   input  logic [DATA_WIDTH-1:0] mem_data_write,
   output logic [DATA_WIDTH-1:0] mem_data_read,
   output logic                  mem_stall,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_read_op,
   output logic                  bus_write_op,
   output logic [DATA_WIDTH-1:0] bus_data_write,
   input  logic [DATA_WIDTH-1:0] bus_data_read,
   input  logic                  bus_stall,
   output logic [1:0]            grant
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOCK_IF  = 2'd1,
      LOCK_MEM = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t     state, state_nxt;
   logic [3:0] starve_cnt;

   logic if_req, mem_req, mem_rd_only;
   logic sel_if, sel_mem;
   logic if_done, mem_done;

   assign if_req      = if_read_op;
   assign mem_req     = mem_read_op | mem_write_op;
   assign mem_rd_only = mem_read_op & ~mem_write_op;

   // Owner selection and next state. In IDLE the winner is chosen in the same
   // cycle so an unstalled SRAM gives single-cycle transactions.
   always_comb begin
      sel_if    = 1'b0;
      sel_mem   = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mem_req && !(if_req && starve_cnt == STARVE_MAX)) begin
               sel_mem = 1'b1;
            end else if (if_req) begin
               sel_if = 1'b1;
            end
            if (sel_mem && bus_stall) state_nxt = LOCK_MEM;
            else if (sel_if && bus_stall) state_nxt = LOCK_IF;
         end
         LOCK_IF: begin
            sel_if = if_req;
            if (!if_req || !bus_stall) state_nxt = IDLE;
         end
         LOCK_MEM: begin
            sel_mem = mem_req;
            if (!mem_req || !bus_stall) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign if_done  = sel_if  & ~bus_stall;
   assign mem_done = sel_mem & ~bus_stall;

   // Output datapath. Reset forces every output low combinationally so the
   // bus is released the moment rst falls, without waiting for a clock.
   always_comb begin
      grant          = 2'b00;
      bus_addr       = '0;
      bus_read_op    = 1'b0;
      bus_write_op   = 1'b0;
      bus_data_write = '0;
      if_stall       = 1'b0;
      mem_stall      = 1'b0;
      if_data_read   = '0;
      mem_data_read  = '0;
      if (rst) begin
         grant = {sel_mem, sel_if};
         if (sel_mem) begin
            bus_addr       = mem_addr;
            bus_read_op    = mem_rd_only;
            bus_write_op   = mem_write_op;
            bus_data_write = mem_data_write;
         end else if (sel_if) begin
            bus_addr    = if_addr;
            bus_read_op = 1'b1;
         end
         if_stall  = if_req  & ~if_done;
         mem_stall = mem_req & ~mem_done;
         if (if_done)                 if_data_read  = bus_data_read;
         if (mem_done && mem_rd_only) mem_data_read = bus_data_read;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
      end else begin
         state <= state_nxt;
         // Counts MEM wins that kept a waiting IF off the bus.
         if (!if_req || if_done) begin
            starve_cnt <= 4'd0;
         end else if (mem_done && starve_cnt < STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int SL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] if_addr = '0;
  logic          if_read_op = 1'b0;
  logic [DW-1:0] if_data_read;
  logic          if_stall;
  logic [AW-1:0] mem_addr = '0;
  logic          mem_read_op = 1'b0;
  logic          mem_write_op = 1'b0;
  logic [DW-1:0] mem_data_write = '0;
  logic [DW-1:0] mem_data_read;
  logic          mem_stall;
  logic [AW-1:0] bus_addr;
  logic          bus_read_op;
  logic          bus_write_op;
  logic [DW-1:0] bus_data_write;
  logic [DW-1:0] bus_data_read;
  logic          bus_stall = 1'b0;
  logic [1:0]    grant;

  sram_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_addr(if_addr), .if_read_op(if_read_op),
    .if_data_read(if_data_read), .if_stall(if_stall),
    .mem_addr(mem_addr), .mem_read_op(mem_read_op), .mem_write_op(mem_write_op),
    .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .mem_stall(mem_stall),
    .bus_addr(bus_addr), .bus_read_op(bus_read_op), .bus_write_op(bus_write_op),
    .bus_data_write(bus_data_write), .bus_data_read(bus_data_read), .bus_stall(bus_stall),
    .grant(grant)
  );

  // ---------------- SRAM behavioural model ----------------
  logic [DW-1:0] sram [0:255];
  assign bus_data_read = sram[bus_addr[7:0]];
  always @(posedge clk)
    if (rst && bus_write_op && !bus_stall) sram[bus_addr[7:0]] <= bus_data_write;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [7:0]    exp_addr_q[$];

  // reference model state: who holds the bus lock (0 none, 1 IF, 2 MEM)
  // and how many MEM wins in a row IF has waited through
  int   m_lock = 0;
  int   m_starve = 0;
  logic e_if_stall = 1'b0;
  logic e_mem_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_bus_ops"}, {30'd0, bus_read_op, bus_write_op}, 32'd0);
    chk({tag, "_bus_wdata"}, bus_data_write, 32'd0);
    chk({tag, "_stalls"}, {30'd0, if_stall, mem_stall}, 32'd0);
    chk({tag, "_if_rdata"}, if_data_read, 32'd0);
    chk({tag, "_mem_rdata"}, mem_data_read, 32'd0);
  endtask

  // One clock cycle: compare at negedge against the model, then advance the
  // model at posedge. want_g >= 0 adds a directed grant check.
  task automatic cycle(input int want_g = -1);
    int w;
    logic done, ifr, memr, mrd, wr_done;
    logic [7:0] wa;
    @(negedge clk);
    ifr  = if_read_op;
    memr = mem_read_op | mem_write_op;
    mrd  = mem_read_op & ~mem_write_op;
    w = 0;
    done = 1'b0;
    wr_done = 1'b0;
    wa = mem_addr[7:0];
    if (!rst) begin
      chk_all_zero("in_reset");
    end else begin
      if (m_lock == 1)      w = ifr ? 1 : 0;
      else if (m_lock == 2) w = memr ? 2 : 0;
      else if (ifr && memr) w = (m_starve == SL) ? 1 : 2;
      else if (memr)        w = 2;
      else if (ifr)         w = 1;
      done = (w != 0) && !bus_stall;
      if (want_g >= 0) chk("directed_grant", 32'(grant), 32'(want_g));
      chk("grant", 32'(grant), (w == 2) ? 32'd2 : (w == 1) ? 32'd1 : 32'd0);
      chk("bus_addr", 32'(bus_addr), (w == 2) ? 32'(mem_addr) : (w == 1) ? 32'(if_addr) : 32'd0);
      chk("bus_read_op", 32'(bus_read_op), 32'((w == 1) || (w == 2 && mrd)));
      chk("bus_write_op", 32'(bus_write_op), 32'(w == 2 && mem_write_op));
      chk("bus_data_write", bus_data_write, (w == 2) ? mem_data_write : 32'd0);
      e_if_stall  = ifr  && !(w == 1 && done);
      e_mem_stall = memr && !(w == 2 && done);
      chk("if_stall", 32'(if_stall), 32'(e_if_stall));
      chk("mem_stall", 32'(mem_stall), 32'(e_mem_stall));
      chk("if_data_read", if_data_read, (w == 1 && done) ? sram[if_addr[7:0]] : 32'd0);
      chk("mem_data_read", mem_data_read, (w == 2 && done && mrd) ? sram[mem_addr[7:0]] : 32'd0);
      wr_done = (w == 2) && done && mem_write_op;
      if (wr_done) begin
        exp_q.push_back(mem_data_write);
        exp_addr_q.push_back(wa);
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_lock = 0;
      m_starve = 0;
      e_if_stall = 1'b0;
      e_mem_stall = 1'b0;
    end else begin
      m_lock = (w != 0 && !done) ? w : 0;
      if (!ifr || (w == 1 && done)) m_starve = 0;
      else if (w == 2 && done && m_starve < SL) m_starve++;
    end
    #1;
    while (exp_q.size() > 0) begin
      logic [DW-1:0] d;
      logic [7:0] a;
      d = exp_q.pop_front();
      a = exp_addr_q.pop_front();
      chk("sram_write", sram[a], d);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_idle();
    if_read_op = 1'b0;
    mem_read_op = 1'b0;
    mem_write_op = 1'b0;
    bus_stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = $urandom;

    // reset state
    cycle();
    cycle();
    rst = 1'b1;
    cycle(0);

    // IF-only read, zero-stall: granted and completed in the same cycle
    if_addr = 20'd5; if_read_op = 1'b1; bus_stall = 1'b0;
    cycle(1);
    drive_idle();

    // simultaneous IF read and MEM write; MEM first, stalls twice
    if_addr = 20'd8; if_read_op = 1'b1;
    mem_addr = 20'd9; mem_write_op = 1'b1; mem_data_write = 32'hDEADBEEF;
    bus_stall = 1'b1;
    cycle(2);
    cycle(2);
    bus_stall = 1'b0;
    cycle(2);
    mem_write_op = 1'b0;
    cycle(1);
    drive_idle();
    chk("deadbeef_stored", sram[9], 32'hDEADBEEF);

    // IF locked; MEM arrives mid-op but must wait
    if_addr = 20'd12; if_read_op = 1'b1; bus_stall = 1'b1;
    cycle(1);
    mem_addr = 20'd20; mem_read_op = 1'b1;
    cycle(1);
    cycle(1);
    bus_stall = 1'b0;
    cycle(1);
    if_read_op = 1'b0;
    cycle(2);
    drive_idle();

    // starvation limit: four MEM wins, then IF, then counter is clear again
    if_addr = 20'd30; if_read_op = 1'b1;
    mem_addr = 20'd40; mem_read_op = 1'b1;
    for (int i = 0; i < SL; i++) cycle(2);
    cycle(1);
    cycle(2);
    drive_idle();
    cycle(0);

    // read and write both raised: treated as a write
    mem_addr = 20'd50; mem_read_op = 1'b1; mem_write_op = 1'b1; mem_data_write = 32'h1234_5678;
    cycle(2);
    drive_idle();

    // asynchronous reset in the middle of a locked MEM transaction
    mem_addr = 20'd60; mem_write_op = 1'b1; mem_data_write = 32'hCAFEF00D;
    bus_stall = 1'b1;
    cycle(2);
    cycle(2);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    cycle();
    rst = 1'b1;
    if_addr = 20'd61; if_read_op = 1'b1; bus_stall = 1'b0;
    cycle(2);
    mem_write_op = 1'b0;
    cycle(1);
    drive_idle();
    cycle(0);

    // randomized traffic, requesters honour the hold-while-stalled rule
    // except for rare deliberate drops
    for (int n = 0; n < 600; n++) begin
      if (!e_if_stall || $urandom_range(0, 29) == 0) begin
        if_read_op = ($urandom_range(0, 2) != 0);
        if_addr = 20'($urandom_range(0, 255));
      end
      if (!e_mem_stall || $urandom_range(0, 29) == 0) begin
        int k;
        k = $urandom_range(0, 4);
        mem_read_op  = (k == 1) || (k == 3);
        mem_write_op = (k == 2) || (k == 3) || (k == 4);
        mem_addr = 20'($urandom_range(0, 255));
        mem_data_write = $urandom;
      end
      bus_stall = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
